gsim_out_buf: RTL and testbench

GSIM_OUT_BUF -- requirements
Module: gsim_out_buf

---
 rtl/gsim_pkg.sv | 15 +
 rtl/gsim_round.sv | 42 ++++
 rtl/gsim_out_buf.sv | 120 ++++++++++++
 tb/tb_gsim_out_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants and FSM state type for the solver output buffer.
//   GSIM_N      : entries per bank
//   GSIM_IDX_W  : bank index width
//   gsim_state_e: drain FSM states
package gsim_pkg;

    localparam int unsigned GSIM_N     = 16;
    localparam int unsigned GSIM_IDX_W = 4;

    typedef enum logic {
        GSIM_IDLE  = 1'b0,
        GSIM_DRAIN = 1'b1
    } gsim_state_e;

endpackage

// File: rtl/gsim_round.sv
// Converts one signed BIT_WIDTH solver word into a signed OUT_WIDTH stream word.
// Macro GSIM_OUT_ROUND_EN: defined   -> round-half-up of the arithmetic shift, saturated
//                          undefined -> arithmetic truncation (drop LSBs)
// Ports:
//   din  : signed two's-complement input word (BIT_WIDTH)
//   dout : converted word (OUT_WIDTH), combinational
module gsim_round #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic [BIT_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] dout
);

    localparam int unsigned SHIFT = BIT_WIDTH - OUT_WIDTH;

    generate
        if (SHIFT == 0) begin : g_ident
            assign dout = din;
        end else begin : g_conv
            logic [OUT_WIDTH-1:0] hi;
            assign hi = din[BIT_WIDTH-1 -: OUT_WIDTH];
`ifdef GSIM_OUT_ROUND_EN
            // Add the first dropped bit; only positive overflow is possible.
            logic [OUT_WIDTH:0] sum;
            logic               ovf;
            assign sum  = {hi[OUT_WIDTH-1], hi} + (OUT_WIDTH+1)'(din[SHIFT-1]);
            assign ovf  = sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1];
            assign dout = ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : sum[OUT_WIDTH-1:0];
            if (SHIFT > 1) begin : g_lsb
                logic unused_lsbs;
                assign unused_lsbs = ^din[SHIFT-2:0];
            end
`else
            logic unused_lsbs;
            assign unused_lsbs = ^din[SHIFT-1:0];
            assign dout        = hi;
`endif
        end
    endgenerate

endmodule

// File: rtl/gsim_out_buf.sv
// Double-banked solver output buffer: results are written into a capture bank,
// a commit snapshots it into a drain bank, which is streamed out word by word
// over a valid/ready interface through gsim_round.
// Macro GSIM_OUT_ROUND_EN selects rounding+saturation in the conversion.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data : capture-bank write
//   commit               : snapshot capture into drain (ignored while draining)
//   busy                 : drain bank still holds unaccepted words
//   out_valid/out_ready  : stream handshake
//   out_data/out_idx/out_last : current converted word, its index, last flag
//   commit_drop          : one-cycle pulse for an ignored commit
module gsim_out_buf
    import gsim_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [GSIM_IDX_W-1:0] wr_idx,
    input  logic [BIT_WIDTH-1:0]  wr_data,
    input  logic                  commit,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [GSIM_IDX_W-1:0] out_idx,
    output logic                  out_last,
    output logic                  commit_drop
);

    localparam logic [GSIM_IDX_W-1:0] LAST_IDX = GSIM_IDX_W'(GSIM_N - 1);

    gsim_state_e           state_q, state_nxt;
    logic [GSIM_IDX_W-1:0] cnt_q, cnt_nxt;
    logic [BIT_WIDTH-1:0]  cap_q   [GSIM_N];
    logic [BIT_WIDTH-1:0]  cap_nxt [GSIM_N];
    logic [BIT_WIDTH-1:0]  drain_q   [GSIM_N];
    logic [BIT_WIDTH-1:0]  drain_nxt [GSIM_N];
    logic                  commit_drop_nxt;
    logic [BIT_WIDTH-1:0]  sel_word;
    logic [OUT_WIDTH-1:0]  conv_word;

    // Conversion of the word that will be presented after this edge.
    gsim_round #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round (
        .din  (sel_word),
        .dout (conv_word)
    );

    // State, banks and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GSIM_IDLE;
            cnt_q       <= '0;
            cap_q       <= '{default: '0};
            drain_q     <= '{default: '0};
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            commit_drop <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            cap_q       <= cap_nxt;
            drain_q     <= drain_nxt;
            busy        <= (state_nxt == GSIM_DRAIN);
            out_valid   <= (state_nxt == GSIM_DRAIN);
            out_data    <= conv_word;
            out_idx     <= cnt_nxt;
            out_last    <= (state_nxt == GSIM_DRAIN) && (cnt_nxt == LAST_IDX);
            commit_drop <= commit_drop_nxt;
        end
    end

    // Next-state: capture writes always land; commit snapshots including this cycle's write.
    always_comb begin
        state_nxt       = state_q;
        cnt_nxt         = cnt_q;
        cap_nxt         = cap_q;
        drain_nxt       = drain_q;
        commit_drop_nxt = 1'b0;

        if (wr_en) begin
            cap_nxt[wr_idx] = wr_data;
        end

        case (state_q)
            GSIM_IDLE: begin
                if (commit) begin
                    drain_nxt = cap_nxt;
                    cnt_nxt   = '0;
                    state_nxt = GSIM_DRAIN;
                end
            end
            GSIM_DRAIN: begin
                commit_drop_nxt = commit;
                // out_valid is high throughout DRAIN, so out_ready alone marks a handshake.
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = GSIM_IDLE;
                    end else begin
                        cnt_nxt = cnt_q + GSIM_IDX_W'(1);
                    end
                end
            end
            default: state_nxt = GSIM_IDLE;
        endcase

        sel_word = drain_nxt[cnt_nxt];
    end

endmodule

// File: tb/tb_gsim_out_buf.sv
// Scoreboard bench for gsim_out_buf: a commit pushes 16 expected words,
// each observed handshake pops and compares one.
module tb_gsim_out_buf;

    typedef struct packed {
        logic        last;
        logic [3:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic        commit;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        commit_drop;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        exp_q[$];
    logic [31:0] cap_m [16];
    logic        m_drain;
    logic [3:0]  m_cnt;
    logic        m_drop;

    always #5 clk = ~clk;

    gsim_out_buf #(.BIT_WIDTH(32), .OUT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .commit      (commit),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .commit_drop (commit_drop)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference conversion using wide integer arithmetic.
    function automatic logic [15:0] conv(input logic [31:0] w);
        longint v;
        v = longint'($signed(w));
`ifdef GSIM_OUT_ROUND_EN
        v = (v + 64'sd32768) >>> 16;
        if (v > 64'sd32767)  v = 64'sd32767;
        if (v < -64'sd32768) v = -64'sd32768;
`else
        v = v >>> 16;
`endif
        return v[15:0];
    endfunction

    // One clock: drive inputs, compare current outputs, advance the model.
    task automatic cycle(input logic we, input logic [3:0] wi, input logic [31:0] wd,
                         input logic cm, input logic rdy);
        exp_t e;
        logic drop_n;
        wr_en = we; wr_idx = wi; wr_data = wd; commit = cm; out_ready = rdy; rst = 1'b0;

        check("valid", 32'(out_valid), 32'(m_drain));
        check("busy", 32'(busy), 32'(m_drain));
        check("drop", 32'(commit_drop), 32'(m_drop));
        if (m_drain) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q[0];
                check("data", 32'(out_data), 32'(e.data));
                check("idx", 32'(out_idx), 32'(e.idx));
                check("last", 32'(out_last), 32'(e.last));
            end
        end

        drop_n = cm && m_drain;
        if (we) cap_m[wi] = wd;
        if (m_drain) begin
            if (rdy) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (m_cnt == 4'd15) begin
                    m_drain = 1'b0;
                    m_cnt   = 4'd0;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end else if (cm) begin
            for (int i = 0; i < 16; i++) begin
                e.data = conv(cap_m[i]);
                e.idx  = 4'(i);
                e.last = (i == 15);
                exp_q.push_back(e);
            end
            m_drain = 1'b1;
            m_cnt   = 4'd0;
        end
        m_drop = drop_n;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; wr_idx = 4'd0; wr_data = 32'd0; commit = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) cap_m[i] = 32'd0;
        m_drain = 1'b0; m_cnt = 4'd0; m_drop = 1'b0;
        exp_q.delete();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(commit_drop), 32'd0);
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
    // Optional one-shot commit (plus write idx 3 = 7) at a chosen index.
    task automatic drain(input int mode, input int drop_at, input logic wr_mid);
        logic rdy;
        logic done_drop;
        done_drop = 1'b0;
        for (int k = 0; k < 300 && m_drain; k++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (!done_drop && int'(m_cnt) == drop_at) begin
                done_drop = 1'b1;
                cycle(wr_mid, 4'd3, 32'h7, 1'b1, rdy);
            end else begin
                cycle(1'b0, 4'd0, 32'd0, 1'b0, rdy);
            end
        end
        check("drain_done", 32'(m_drain), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);

        // Index-valued words, full-rate drain.
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 32'(i) << 16, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        drain(0, -1, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("s1_empty", 32'(exp_q.size()), 32'd0);

        // Stalls with ready pattern 1,0,0,1.
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        drain(1, -1, 1'b0);

        // Commit dropped at index 5 with a capture write mid-drain, then re-commit.
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        drain(0, 5, 1'b1);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        drain(2, 15, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);

        // Write-through on the commit cycle.
        cycle(1'b1, 4'd0, 32'h0001_8000, 1'b1, 1'b1);
        drain(0, -1, 1'b0);

        // Conversion boundaries.
        cycle(1'b1, 4'd0, 32'h7FFF_FFFF, 1'b0, 1'b0);
        cycle(1'b1, 4'd1, 32'h8000_0000, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 32'hFFFF_8000, 1'b0, 1'b0);
        cycle(1'b1, 4'd3, 32'hFFFF_7FFF, 1'b0, 1'b0);
        cycle(1'b1, 4'd4, 32'h0000_7FFF, 1'b0, 1'b0);
        cycle(1'b1, 4'd5, 32'h7FFF_8000, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 32'h8000_7FFF, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        drain(2, -1, 1'b0);

        // Reset at drain index 8, then a drain of zeros.
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom | 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        for (int k = 0; k < 40 && m_cnt != 4'd8; k++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        check("at_idx8", 32'(m_cnt), 32'd8);
        do_reset();
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
        drain(0, -1, 1'b0);

        // A few random drains.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom, 1'b0, 1'b0);
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b1, 1'b0);
            drain(2, int'($urandom_range(0, 15)), 1'b1);
        end
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
